// File: rtl/sp_ram_fifo_pkg.sv
// Shared definitions for the single-port-RAM FIFO controller: default widths
// and the read-handshake FSM state encoding.
package sp_ram_fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_ADD_WIDTH  = 4;

    typedef logic [0:0] fsm_state_t;

    localparam fsm_state_t IDLE    = 1'b0;
    localparam fsm_state_t RD_WAIT = 1'b1;

endpackage

// File: rtl/sp_ram_arb.sv
// Two-requester round-robin arbiter between RAM reads and writes.
// Under contention the grant goes to whichever side lost last time; reads win first after reset.
module sp_ram_arb
    import sp_ram_fifo_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic rd_req,
    input  logic wr_req,
    output logic rd_gnt,
    output logic wr_gnt
);

    logic wr_next;
    logic contention;

    assign contention = rd_req && wr_req;
    assign rd_gnt     = rd_req && (!wr_req || !wr_next);
    assign wr_gnt     = wr_req && (!rd_req || wr_next);

    // The priority bit only moves when both sides actually competed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_next <= 1'b0;
        end else if (contention) begin
            wr_next <= !wr_next;
        end
    end

endmodule

// File: rtl/sp_ram_fifo_ctrl.sv
// FIFO controller wrapped around an external single-port RAM with one-cycle read latency.
// Optional sticky overflow/underflow flags are enabled by defining SP_RAM_FIFO_ERR_EN.
module sp_ram_fifo_ctrl
    import sp_ram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADD_WIDTH  = DEFAULT_ADD_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  ram_we,
    output logic [ADD_WIDTH-1:0]  ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic [ADD_WIDTH:0]    count,
    output logic                  full,
    output logic                  empty
`ifdef SP_RAM_FIFO_ERR_EN
    ,
    output logic                  ovf_err,
    output logic                  udf_err
`endif
);

    localparam int DEPTH = 2 ** ADD_WIDTH;
    localparam logic [ADD_WIDTH:0] DEPTH_CNT = (ADD_WIDTH + 1)'(DEPTH);

    fsm_state_t           state;
    logic [ADD_WIDTH-1:0] wptr;
    logic [ADD_WIDTH-1:0] rptr;
    logic                 rd_req;
    logic                 wr_req;
    logic                 rd_gnt;
    logic                 wr_gnt;

    assign full  = (count == DEPTH_CNT);
    assign empty = (count == '0);

    // A read may refill the output register only once its current word is gone or leaving.
    assign rd_req = !reset && (state == IDLE) && !empty && (!rd_valid || rd_ready);
    assign wr_req = !reset && wr_valid && !full;

    sp_ram_arb u_arb (
        .clk    (clk),
        .reset  (reset),
        .rd_req (rd_req),
        .wr_req (wr_req),
        .rd_gnt (rd_gnt),
        .wr_gnt (wr_gnt)
    );

    assign wr_ready = !reset && !full && !rd_gnt;
    assign ram_we   = wr_gnt;
    assign ram_addr = wr_gnt ? wptr : rptr;
    assign ram_data = wr_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_gnt) begin
                wptr  <= wptr + 1'b1;
                count <= count + 1'b1;
            end else if (rd_gnt) begin
                rptr  <= rptr + 1'b1;
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    state <= rd_gnt ? RD_WAIT : IDLE;
                RD_WAIT: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // RAM data is valid during RD_WAIT; a reset in that cycle drops the word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else if (state == RD_WAIT) begin
            rd_valid <= 1'b1;
            rd_data  <= ram_rdata;
        end else if (rd_valid && rd_ready) begin
            rd_valid <= 1'b0;
        end
    end

`ifdef SP_RAM_FIFO_ERR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_err <= 1'b0;
            udf_err <= 1'b0;
        end else begin
            if (wr_valid && full) begin
                ovf_err <= 1'b1;
            end
            if (rd_ready && !rd_valid && empty && (state == IDLE)) begin
                udf_err <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sp_ram_fifo_ctrl.sv
// Directed self-checking bench for sp_ram_fifo_ctrl with a behavioural single-port RAM
// and an in-order word scoreboard.
module tb_sp_ram_fifo_ctrl;

    logic       clk;
    logic       reset;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_data;
    logic       rd_valid;
    logic       rd_ready;
    logic [7:0] rd_data;
    logic       ram_we;
    logic [3:0] ram_addr;
    logic [7:0] ram_data;
    logic [7:0] ram_rdata;
    logic [4:0] count;
    logic       full;
    logic       empty;
`ifdef SP_RAM_FIFO_ERR_EN
    logic       ovf_err;
    logic       udf_err;
`endif

    logic [7:0] mem [0:15];
    logic [7:0] sbq [$];
    logic [3:0] mwptr;
    logic [7:0] nextWord;
    logic [7:0] popped;
    logic [5:0] fillWe;
    logic [7:0] altWe;
    int         altCount [8];
    int         accepted;
    int         checkCount;
    int         failCount;

    sp_ram_fifo_ctrl #(.DATA_WIDTH(8), .ADD_WIDTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_data  (ram_data),
        .ram_rdata (ram_rdata),
        .count     (count),
        .full      (full),
        .empty     (empty)
`ifdef SP_RAM_FIFO_ERR_EN
        ,
        .ovf_err   (ovf_err),
        .udf_err   (udf_err)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single-port RAM: synchronous write, registered read of the presented address.
    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_data;
        end
        ram_rdata <= mem[ram_addr];
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle's inputs, then record accepted writes and check delivered reads.
    task automatic applyStimulus(input logic wv, input logic [7:0] wd, input logic rr);
        @(negedge clk);
        wr_valid = wv;
        wr_data  = wd;
        rd_ready = rr;
        #1;
        if (wr_valid && wr_ready) begin
            checkOutput("wr_ram_we", ram_we, 1);
            checkOutput("wr_addr", ram_addr, mwptr);
            checkOutput("wr_ram_data", ram_data, wr_data);
            sbq.push_back(wr_data);
            mwptr = mwptr + 4'd1;
        end
        if (rd_valid && rd_ready) begin
            checkOutput("rd_sb_nonempty", sbq.size() > 0, 1);
            if (sbq.size() > 0) begin
                popped = sbq.pop_front();
                checkOutput("rd_order", rd_data, popped);
            end
        end
    endtask

    task automatic applyReset();
        @(negedge clk);
        reset    = 1'b1;
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        #1;
        sbq.delete();
        mwptr = 4'd0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        checkCount = 0;
        failCount  = 0;
        mwptr      = 4'd0;
        reset      = 1'b1;
        wr_valid   = 1'b0;
        wr_data    = 8'h00;
        rd_ready   = 1'b0;
        fillWe     = 6'b111101;
        altWe      = 8'b01101101;
        altCount   = '{4, 5, 4, 5, 6, 5, 6, 7};

        // Reset state and gating while reset is held
        repeat (2) @(negedge clk);
        wr_valid = 1'b1;
        #1;
        checkOutput("rst_wr_ready", wr_ready, 0);
        checkOutput("rst_ram_we", ram_we, 0);
        wr_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("rst_rd_valid", rd_valid, 0);
        checkOutput("rst_rd_data", rd_data, 0);
        checkOutput("rst_count", count, 0);
        checkOutput("rst_empty", empty, 1);
        checkOutput("rst_full", full, 0);
        checkOutput("rst_ram_addr", ram_addr, 0);

        // Fill with rd_ready low: word 1 is prefetched into rd_data, so 17 words fit
        applyStimulus(1'b1, 8'h01, 1'b0);
        checkOutput("fill_first_we", ram_we, 1);
        applyStimulus(1'b1, 8'h02, 1'b0);
        checkOutput("fill_read_we", ram_we, 0);
        checkOutput("fill_read_addr", ram_addr, 0);
        checkOutput("fill_read_blocks_wr", wr_ready, 0);
        for (int k = 2; k <= 17; k++) begin
            applyStimulus(1'b1, 8'(k), 1'b0);
            checkOutput("fill_wr_ready", wr_ready, 1);
            checkOutput("fill_count", count, k - 2);
        end
        applyStimulus(1'b1, 8'h12, 1'b0);
        checkOutput("full_flag", full, 1);
        checkOutput("full_count", count, 16);
        checkOutput("full_wr_ready", wr_ready, 0);
        checkOutput("full_ram_we", ram_we, 0);
        checkOutput("full_rd_valid", rd_valid, 1);
        checkOutput("full_rd_data", rd_data, 8'h01);

        // Drain: next word appears two cycles after its read is issued
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("drain_issue_we", ram_we, 0);
        checkOutput("drain_issue_addr", ram_addr, 1);
        checkOutput("drain_issue_count", count, 16);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("drain_wait_valid", rd_valid, 0);
        checkOutput("drain_wait_count", count, 15);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("drain_lat_valid", rd_valid, 1);
        checkOutput("drain_lat_data", rd_data, 8'h02);
        for (int i = 0; i < 100 && sbq.size() > 0; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1);
        end
        checkOutput("drain_complete", sbq.size(), 0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("drain_rd_valid", rd_valid, 0);
        checkOutput("drain_empty", empty, 1);
        checkOutput("drain_count", count, 0);

        // Build count=4 from reset, then contend continuously
        applyReset();
        nextWord = 8'h21;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, nextWord, 1'b0);
            checkOutput("alt_fill_we", ram_we, fillWe[i]);
            if (wr_ready) nextWord++;
        end
        @(negedge clk);
        wr_valid = 1'b0;
        #1;
        checkOutput("alt_start_count", count, 4);
        checkOutput("alt_start_data", rd_data, 8'h21);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, nextWord, 1'b1);
            checkOutput("alt_ram_we", ram_we, altWe[i]);
            checkOutput("alt_count", count, altCount[i]);
            if (wr_ready) nextWord++;
        end

        // 20 more words with concurrent reads; write addresses wrap past 15
        accepted = 0;
        for (int i = 0; i < 200 && accepted < 20; i++) begin
            applyStimulus(1'b1, nextWord, 1'b1);
            if (wr_ready) begin
                nextWord++;
                accepted++;
            end
        end
        checkOutput("stream_accepted", accepted, 20);
        for (int i = 0; i < 200 && sbq.size() > 0; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1);
        end
        checkOutput("stream_drained", sbq.size(), 0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("stream_empty", empty, 1);
        checkOutput("stream_rd_valid", rd_valid, 0);

        // Reset while a read is in flight with three words stored
        applyReset();
        applyStimulus(1'b1, 8'hA1, 1'b0);
        checkOutput("flight_w1_we", ram_we, 1);
        applyStimulus(1'b1, 8'hA2, 1'b0);
        checkOutput("flight_first_read", ram_we, 0);
        applyStimulus(1'b1, 8'hA2, 1'b0);
        applyStimulus(1'b1, 8'hA3, 1'b0);
        applyStimulus(1'b1, 8'hA4, 1'b0);
        applyStimulus(1'b1, 8'hA5, 1'b1);
        checkOutput("flight_count3", count, 3);
        checkOutput("flight_wr_wins", ram_we, 1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("flight_issue_we", ram_we, 0);
        checkOutput("flight_issue_count", count, 4);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("flight_wait_count", count, 3);
        checkOutput("flight_wait_valid", rd_valid, 0);
        reset    = 1'b1;
        wr_valid = 1'b1;
        #1;
        checkOutput("flight_rst_count", count, 0);
        checkOutput("flight_rst_empty", empty, 1);
        checkOutput("flight_rst_ram_we", ram_we, 0);
        checkOutput("flight_rst_wr_ready", wr_ready, 0);
        @(negedge clk);
        checkOutput("flight_dropped", rd_valid, 0);
        reset    = 1'b0;
        wr_valid = 1'b0;
        sbq.delete();
        mwptr = 4'd0;
        applyStimulus(1'b1, 8'hAA, 1'b0);
        checkOutput("post_rst_we", ram_we, 1);
        applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("post_rst_valid", rd_valid, 1);
        checkOutput("post_rst_data", rd_data, 8'hAA);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("post_rst_empty", empty, 1);

`ifdef SP_RAM_FIFO_ERR_EN
        // Sticky overflow/underflow flags
        checkOutput("err_init_ovf", ovf_err, 0);
        checkOutput("err_init_udf", udf_err, 0);
        for (int i = 0; i < 40 && !full; i++) begin
            applyStimulus(1'b1, 8'(8'h40 + i), 1'b0);
        end
        checkOutput("err_full", full, 1);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("err_ovf_clear", ovf_err, 0);
        applyStimulus(1'b1, 8'h77, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("err_ovf_set", ovf_err, 1);
        for (int i = 0; i < 100 && sbq.size() > 0; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1);
        end
        checkOutput("err_ovf_held", ovf_err, 1);
        checkOutput("err_udf_clear", udf_err, 0);
        applyStimulus(1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("err_udf_set", udf_err, 1);
        applyReset();
        #1;
        checkOutput("err_rst_ovf", ovf_err, 0);
        checkOutput("err_rst_udf", udf_err, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
